dlx_pipe_if: RTL and testbench
==============================

# dlx_pipe_if

DLX instruction fetch pipe stage. It owns the program counter and drives the instruction-memory request interface. It loads the IF/ID pipeline register (`if_id_ir`, `if_id_npc`) that the decode stage consumes. It also accepts the decode stage's return path: taken-branch redirect (`id_cond`/`id_npc`), halt and illegal-instruction. Wait states, squashes and pipeline freezes are resolved with a five-state FSM and a one-entry fetch buffer.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hazard freeze from forwarding/hazard control.
- `dc_wait`  in  1  data-cache wait; freezes the pipe.
- `id_cond`  in  1  ID resolved a taken branch/jump.
- `id_npc`  in  32  redirect target (`dlx_word`).
- `id_halt`  in  1  ID decoded a halt.
- `id_illegal_instr`  in  1  ID decoded an illegal instruction.
- `if_ic_en`  out  1  instruction-memory request.
- `if_ic_addr`  out  32  fetch address, equal to the PC.
- `ic_rdata`  in  32  instruction word; valid when `if_ic_en & ~ic_wait`.
- `ic_wait`  in  1  memory not ready. `if_ic_addr` must stay stable while it is high.
- `if_id_ir`  out  32  IF/ID instruction register.
- `if_id_npc`  out  32  IF/ID next PC (fetch address + 4).
- `if_halted`  out  1  high in HALTED.

## Operation
- freeze = `stall | dc_wait`. redir = `id_cond & ~freeze`. stop = `(id_halt | id_illegal_instr) & ~freeze`.
- Priority order: `rst`, then stop, then freeze, then redir, then `ic_wait`.
- Reset values: PC = `RESET_PC`; `if_id_ir` = `DLX_NOP`; `if_id_npc` = 0; state = RUN; fetch buffer empty; pending target = 0; pending-halt = 0; `if_ic_en` = 0 while `rst` is high.
- `if_ic_en` by state:
  - RUN: `~freeze & ~stop`
  - IC_WAIT, SQUASH: 1
  - HOLD, HALTED: 0
- RUN:
  - stop: go to HALTED; IF/ID ← NOP.
  - freeze: hold everything.
  - redir with `ic_wait` = 0: PC ← `id_npc`; IF/ID ← NOP; fetched word discarded.
  - redir with `ic_wait` = 1: pending target ← `id_npc`; IF/ID ← NOP; go to SQUASH.
  - `ic_wait` = 1 (no redir): IF/ID ← NOP; go to IC_WAIT.
  - Otherwise: IF/ID ← {`ic_rdata`, PC+4}; PC ← PC+4.
- IC_WAIT: request held. On entry, IF/ID holds NOP unless frozen.
  - stop: pending-halt ← 1; go to SQUASH.
  - redir: pending target ← `id_npc`; go to SQUASH.
  - Data arrives with no freeze: IF/ID ← {`ic_rdata`, PC+4}; PC ← PC+4; go to RUN.
  - Data arrives with freeze: buffer ← `ic_rdata`; go to HOLD.
- SQUASH: request held.
  - On completion, data is discarded.
  - If pending-halt: go to HALTED. Otherwise PC ← pending target and go to RUN.
  - IF/ID ← NOP on completion unless frozen.
  - Further redir while in SQUASH overwrites the pending target.
- HOLD: no request.
  - freeze: hold.
  - stop: go to HALTED; buffer dropped.
  - redir: PC ← `id_npc`; IF/ID ← NOP; buffer dropped; go to RUN.
  - Otherwise: IF/ID ← {buffer, PC+4}; PC ← PC+4; go to RUN.
- HALTED: absorbing. PC and IF/ID hold (IF/ID = NOP); only `rst` exits.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No alignment check; `id_npc` is used verbatim.
- Any held state (frozen RUN, IC_WAIT, HOLD) holds the IF/ID contents unchanged. A NOP bubble is written only when the stage is not frozen.

## Timing
- Zero-wait memory: one instruction per cycle. The word fetched in cycle n appears on `if_id_ir` in cycle n+1.
- Each wait cycle inserts one bubble. The address is held until the cycle in which `ic_wait` = 0.
- Redirect penalty is one NOP bubble. The target is fetched the cycle after `id_cond`, or on the cycle after completion when a fetch was in flight.
- `rst` asserted in any state, including mid-wait: the next cycle is in reset values. The outstanding memory transaction is abandoned; memory must tolerate `if_ic_en` dropping.
- `if_halted` rises the cycle after the accepted stop.

## Structure
- Shared package `dlx_global_pkg` gains:
  - `DLX_NOP` constant (32'h0000_0000)
  - `DLX_PC_INC` (4)
  - `if_state` enum {RUN, IC_WAIT, SQUASH, HOLD, HALTED}
  - reuses `dlx_word`
- Single module with no sub-modules. The fetch buffer is one 32-bit register plus the FSM.

## Test plan
- `RESET_PC` = 32'h100, zero-wait memory returning {addr}: after reset `if_id_ir` = 0x100, 0x104, 0x108 on consecutive cycles, with `if_id_npc` = 0x104, 0x108, 0x10C.
- `ic_wait` high 2 cycles at 0x108: `if_ic_addr` holds 0x108; two NOP bubbles; then `if_id_ir` = 0x108, `if_id_npc` = 0x10C.
- `id_cond` = 1, `id_npc` = 0x200 with zero-wait memory: next `if_id_ir` = NOP; next `if_ic_addr` = 0x200.
- `id_cond` (target 0x200) in the first of 3 wait cycles at 0x108: address holds 0x108 through completion, data is discarded, then `if_ic_addr` = 0x200.
- `stall` high 3 cycles while a wait completes at 0x10C: state is HOLD, `if_ic_en` = 0, IF/ID unchanged. After release, `if_id_ir` = 0x10C and the next fetch is at 0x110.
- `id_halt` pulse: `if_id_ir` = NOP, `if_halted` = 1, `if_ic_en` = 0 for 10 or more cycles. `rst` then restarts fetch at 0x100.

Source files
------------

// File: rtl/dlx_global_pkg.sv
// Shared DLX types and constants used across the pipeline stages.
// The fetch stage takes its word type, NOP encoding, PC step and FSM states from here.
package dlx_global_pkg;

  typedef logic [31:0] dlx_word;

  localparam dlx_word DLX_NOP    = 32'h0000_0000;
  localparam dlx_word DLX_PC_INC = 32'd4;

  typedef enum logic [2:0] {
    RUN,
    IC_WAIT,
    SQUASH,
    HOLD,
    HALTED
  } if_state;

endpackage

// File: rtl/dlx_pipe_if.sv
// DLX instruction fetch stage: owns the PC, drives the instruction-memory request and loads IF/ID.
// Memory wait states, redirect squashes and pipeline freezes are handled by a five-state FSM.
module dlx_pipe_if
  import dlx_global_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        dc_wait,
  input  logic        id_cond,
  input  logic [31:0] id_npc,
  input  logic        id_halt,
  input  logic        id_illegal_instr,
  output logic        if_ic_en,
  output logic [31:0] if_ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_wait,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_npc,
  output logic        if_halted
);

  if_state state_q, state_d;
  dlx_word pc_q, pc_d;
  dlx_word ir_q, ir_d;
  dlx_word npc_q, npc_d;
  dlx_word buf_q, buf_d;
  dlx_word pend_tgt_q, pend_tgt_d;
  logic    pend_halt_q, pend_halt_d;

  logic    freeze;
  logic    redir;
  logic    stop;
  logic    ic_en;
  dlx_word pc_inc;

  assign freeze = stall | dc_wait;
  assign redir  = id_cond & ~freeze;
  assign stop   = (id_halt | id_illegal_instr) & ~freeze;
  assign pc_inc = pc_q + DLX_PC_INC;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    npc_d       = npc_q;
    buf_d       = buf_q;
    pend_tgt_d  = pend_tgt_q;
    pend_halt_d = pend_halt_q;
    ic_en       = 1'b0;

    case (state_q)
      RUN: begin
        ic_en = ~freeze & ~stop;
        if (stop) begin
          state_d = HALTED;
          ir_d    = DLX_NOP;
        end else if (!freeze) begin
          if (redir) begin
            ir_d = DLX_NOP;
            if (ic_wait) begin
              pend_tgt_d = id_npc;
              state_d    = SQUASH;
            end else begin
              pc_d = id_npc;
            end
          end else if (ic_wait) begin
            ir_d    = DLX_NOP;
            state_d = IC_WAIT;
          end else begin
            ir_d  = ic_rdata;
            npc_d = pc_inc;
            pc_d  = pc_inc;
          end
        end
      end

      IC_WAIT: begin
        ic_en = 1'b1;
        if (stop) begin
          pend_halt_d = 1'b1;
          state_d     = SQUASH;
        end else if (redir) begin
          pend_tgt_d = id_npc;
          state_d    = SQUASH;
        end else if (!ic_wait) begin
          if (freeze) begin
            buf_d   = ic_rdata;
            state_d = HOLD;
          end else begin
            ir_d    = ic_rdata;
            npc_d   = pc_inc;
            pc_d    = pc_inc;
            state_d = RUN;
          end
        end
      end

      SQUASH: begin
        // The in-flight fetch must complete at its original address; only then is the target taken.
        ic_en = 1'b1;
        if (redir) begin
          pend_tgt_d = id_npc;
        end
        if (!ic_wait) begin
          if (!freeze) begin
            ir_d = DLX_NOP;
          end
          if (pend_halt_q) begin
            state_d = HALTED;
          end else begin
            pc_d    = redir ? id_npc : pend_tgt_q;
            state_d = RUN;
          end
        end
      end

      HOLD: begin
        if (stop) begin
          ir_d    = DLX_NOP;
          state_d = HALTED;
        end else if (!freeze) begin
          if (redir) begin
            pc_d = id_npc;
            ir_d = DLX_NOP;
          end else begin
            ir_d  = buf_q;
            npc_d = pc_inc;
            pc_d  = pc_inc;
          end
          state_d = RUN;
        end
      end

      HALTED: begin
        ic_en = 1'b0;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      ir_q        <= DLX_NOP;
      npc_q       <= '0;
      pend_tgt_q  <= '0;
      pend_halt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      npc_q       <= npc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_halt_q <= pend_halt_d;
    end
  end

  // NOTE: the fetch buffer is only read in HOLD, which always follows a write, so its data needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign if_ic_en   = ic_en & ~rst;
  assign if_ic_addr = pc_q;
  assign if_id_ir   = ir_q;
  assign if_id_npc  = npc_q;
  assign if_halted  = (state_q == HALTED);

endmodule

// File: tb/tb_dlx_pipe_if.sv
// Directed bench for dlx_pipe_if: memory returns its own address, expected IF/ID words
// are queued before each clock and compared after it.
module tb_dlx_pipe_if;
  import dlx_global_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        dc_wait;
  logic        id_cond;
  logic [31:0] id_npc;
  logic        id_halt;
  logic        id_illegal_instr;
  logic        if_ic_en;
  logic [31:0] if_ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_wait;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;
  logic        if_halted;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
    logic        chk_npc;
  } ifid_t;

  ifid_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_step   = 0;

  dlx_pipe_if #(.RESET_PC(32'h100)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .dc_wait          (dc_wait),
    .id_cond          (id_cond),
    .id_npc           (id_npc),
    .id_halt          (id_halt),
    .id_illegal_instr (id_illegal_instr),
    .if_ic_en         (if_ic_en),
    .if_ic_addr       (if_ic_addr),
    .ic_rdata         (ic_rdata),
    .ic_wait          (ic_wait),
    .if_id_ir         (if_id_ir),
    .if_id_npc        (if_id_npc),
    .if_halted        (if_halted)
  );

  // Instruction memory model: the word at an address is the address itself.
  assign ic_rdata = if_ic_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s (step %0d): observed %h expected %h", tag, n_step, obs, exp);
  endtask

  task automatic push(input logic [31:0] ir, input logic [31:0] npc, input logic chk_npc);
    ifid_t e;
    e.ir      = ir;
    e.npc     = npc;
    e.chk_npc = chk_npc;
    sb_q.push_back(e);
  endtask

  task automatic push_fetch(input logic [31:0] addr);
    push(addr, addr + 32'd4, 1'b1);
  endtask

  task automatic push_bubble();
    push(DLX_NOP, 32'h0, 1'b0);
  endtask

  // One clock; afterwards compare IF/ID against the oldest queued expectation.
  task automatic step();
    ifid_t e;
    @(posedge clk);
    #1;
    n_step++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("if_id_ir", if_id_ir, e.ir);
      if (e.chk_npc) check("if_id_npc", if_id_npc, e.npc);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; dc_wait = 1'b0; id_cond = 1'b0; id_npc = '0;
    id_halt = 1'b0; id_illegal_instr = 1'b0; ic_wait = 1'b0;

    // Reset state
    step();
    push(DLX_NOP, 32'h0, 1'b1);
    step();
    check("rst_ic_en", {31'b0, if_ic_en}, 32'h0);
    check("rst_addr", if_ic_addr, 32'h100);
    check("rst_halted", {31'b0, if_halted}, 32'h0);
    rst = 1'b0;
    #1;
    check("run_ic_en", {31'b0, if_ic_en}, 32'h1);

    // Zero-wait streaming
    push_fetch(32'h100); step();
    push_fetch(32'h104); step();
    check("addr_before_wait", if_ic_addr, 32'h108);

    // Two wait cycles at 0x108
    ic_wait = 1'b1;
    push_bubble(); step();
    check("wait_addr1", if_ic_addr, 32'h108);
    push_bubble(); step();
    check("wait_addr2", if_ic_addr, 32'h108);
    check("wait_ic_en", {31'b0, if_ic_en}, 32'h1);
    ic_wait = 1'b0;
    push_fetch(32'h108); step();

    // Redirect with zero-wait memory
    id_cond = 1'b1; id_npc = 32'h200;
    push_bubble(); step();
    check("redir_addr", if_ic_addr, 32'h200);
    id_cond = 1'b0;
    push_fetch(32'h200); step();
    id_cond = 1'b1; id_npc = 32'h108;
    push_bubble(); step();
    id_cond = 1'b0;

    // Redirect in the first of three wait cycles at 0x108
    ic_wait = 1'b1; id_cond = 1'b1; id_npc = 32'h200;
    push_bubble(); step();
    id_cond = 1'b0;
    check("squash_addr1", if_ic_addr, 32'h108);
    push_bubble(); step();
    check("squash_addr2", if_ic_addr, 32'h108);
    push_bubble(); step();
    check("squash_addr3", if_ic_addr, 32'h108);
    ic_wait = 1'b0;
    push_bubble(); step();
    check("squash_target", if_ic_addr, 32'h200);
    push_fetch(32'h200); step();

    // Wait completes at 0x10C under a 3-cycle stall
    id_cond = 1'b1; id_npc = 32'h10C;
    push_bubble(); step();
    id_cond = 1'b0; ic_wait = 1'b1;
    push_bubble(); step();
    stall = 1'b1; ic_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_bubble(); step();
      check("hold_ic_en", {31'b0, if_ic_en}, 32'h0);
      check("hold_addr", if_ic_addr, 32'h10C);
    end
    stall = 1'b0;
    push_fetch(32'h10C); step();
    check("after_hold_addr", if_ic_addr, 32'h110);
    push_fetch(32'h110); step();

    // Frozen RUN holds IF/ID
    dc_wait = 1'b1;
    #1;
    check("freeze_ic_en", {31'b0, if_ic_en}, 32'h0);
    push_fetch(32'h110); step();
    dc_wait = 1'b0;
    push_fetch(32'h114); step();

    // PC wrap at the top of the address space
    id_cond = 1'b1; id_npc = 32'hFFFF_FFFC;
    push_bubble(); step();
    id_cond = 1'b0;
    push_fetch(32'hFFFF_FFFC); step();
    check("wrap_addr", if_ic_addr, 32'h0);
    push_fetch(32'h0); step();

    // Halt pulse, then absorbing HALTED
    id_halt = 1'b1;
    #1;
    check("halt_req_ic_en", {31'b0, if_ic_en}, 32'h0);
    push_bubble(); step();
    id_halt = 1'b0;
    check("halted", {31'b0, if_halted}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      push_bubble(); step();
      check("halted_hold", {31'b0, if_halted}, 32'h1);
      check("halted_ic_en", {31'b0, if_ic_en}, 32'h0);
      check("halted_addr", if_ic_addr, 32'h4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("restart_addr", if_ic_addr, 32'h100);
    check("restart_halted", {31'b0, if_halted}, 32'h0);
    push_fetch(32'h100); step();

    // Illegal instruction during a wait ends in HALTED after the fetch completes
    ic_wait = 1'b1;
    push_bubble(); step();
    id_illegal_instr = 1'b1;
    push_bubble(); step();
    id_illegal_instr = 1'b0;
    check("illegal_not_yet", {31'b0, if_halted}, 32'h0);
    ic_wait = 1'b0;
    push_bubble(); step();
    check("illegal_halted", {31'b0, if_halted}, 32'h1);

    // Reset asserted mid-wait
    rst = 1'b1;
    step();
    rst = 1'b0;
    ic_wait = 1'b1;
    push_bubble(); step();
    rst = 1'b1;
    #1;
    check("rst_midwait_ic_en", {31'b0, if_ic_en}, 32'h0);
    push(DLX_NOP, 32'h0, 1'b1); step();
    rst = 1'b0; ic_wait = 1'b0;
    check("rst_midwait_addr", if_ic_addr, 32'h100);
    push_fetch(32'h100); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
